axi4lite_sram_slave: RTL and testbench

- AXI4-Lite slave RAM that consumes the mem_axi_* master channels driven by the PicoRV32 AXI adapter.
- Replaces the native-bus memory model so the core runs entirely over AXI.
- Word-organised storage with byte-strobe writes.
- Independent read and write FSMs, one outstanding transaction per direction, and a configurable wait-state counter to stress master handshakes.

---
 rtl/axi4lite_sram_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi4lite_sram_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave RAM for the PicoRV32 mem_axi_* master channels.
// Word-organised storage with byte-strobe writes, independent read/write
// FSMs (one outstanding transaction each) and a programmable wait-state
// delay ahead of bvalid/rvalid.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_axi_aw*                write address channel (awprot ignored)
//   mem_axi_w*                 write data channel, wstrb bit i -> wdata[8i+7:8i]
//   mem_axi_b*                 write response channel (always OKAY, no bresp)
//   mem_axi_ar*                read address channel (arprot ignored)
//   mem_axi_r*                 read data channel
module axi4lite_sram_slave #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata
);

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] W_COLLECT = 2'd0;
   localparam logic [1:0] W_WAIT    = 2'd1;
   localparam logic [1:0] W_RESP    = 2'd2;

   localparam logic [1:0] R_IDLE    = 2'd0;
   localparam logic [1:0] R_WAIT    = 2'd1;
   localparam logic [1:0] R_DATA    = 2'd2;

   logic [31:0] mem [MEM_WORDS];

   // Byte address -> word index; out-of-range addresses wrap.
   function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
      return IDX_W'((addr - ADDR_BASE) >> 2);
   endfunction

   // Write-side state
   logic [1:0]       w_state,   w_state_n;
   logic             aw_held,   aw_held_n;
   logic             w_held,    w_held_n;
   logic [IDX_W-1:0] aw_idx_q,  aw_idx_n;
   logic [31:0]      wdata_q,   wdata_n;
   logic [3:0]       wstrb_q,   wstrb_n;
   logic [CNT_W-1:0] w_cnt,     w_cnt_n;
   logic             awready_q, awready_n;
   logic             wready_q,  wready_n;
   logic             bvalid_q,  bvalid_n;
   logic             mem_we_c;

   // Read-side state
   logic [1:0]       r_state,   r_state_n;
   logic [IDX_W-1:0] ar_idx_q,  ar_idx_n;
   logic [CNT_W-1:0] r_cnt,     r_cnt_n;
   logic             arready_q, arready_n;
   logic             rvalid_q,  rvalid_n;
   logic [31:0]      rdata_q;
   logic             rd_sample_c;

   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = mem_axi_awvalid && awready_q;
   assign w_hs  = mem_axi_wvalid  && wready_q;
   assign ar_hs = mem_axi_arvalid && arready_q;

   logic unused_prot;
   assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

   // Write FSM next-state: collect AW/W in any order, wait, commit, respond.
   always_comb begin
      w_state_n = w_state;
      aw_held_n = aw_held;
      w_held_n  = w_held;
      aw_idx_n  = aw_idx_q;
      wdata_n   = wdata_q;
      wstrb_n   = wstrb_q;
      w_cnt_n   = w_cnt;
      awready_n = awready_q;
      wready_n  = wready_q;
      bvalid_n  = bvalid_q;
      mem_we_c  = 1'b0;
      case (w_state)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_held_n = 1'b1;
               aw_idx_n  = word_index(mem_axi_awaddr);
            end
            if (w_hs) begin
               w_held_n = 1'b1;
               wdata_n  = mem_axi_wdata;
               wstrb_n  = mem_axi_wstrb;
            end
            awready_n = !aw_held_n;
            wready_n  = !w_held_n;
            if (aw_held_n && w_held_n) begin
               w_state_n = W_WAIT;
               w_cnt_n   = CNT_W'(WAIT_CYCLES);
            end
         end
         W_WAIT: begin
            if (w_cnt == '0) begin
               mem_we_c  = 1'b1;
               bvalid_n  = 1'b1;
               w_state_n = W_RESP;
            end else begin
               w_cnt_n = w_cnt - CNT_W'(1);
            end
         end
         W_RESP: begin
            if (mem_axi_bready) begin
               bvalid_n  = 1'b0;
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
               w_state_n = W_COLLECT;
            end
         end
         default: w_state_n = W_COLLECT;
      endcase
   end

   // Read FSM next-state: accept AR, wait, sample memory, hold data until taken.
   always_comb begin
      r_state_n   = r_state;
      ar_idx_n    = ar_idx_q;
      r_cnt_n     = r_cnt;
      arready_n   = arready_q;
      rvalid_n    = rvalid_q;
      rd_sample_c = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready_n = 1'b1;
            if (ar_hs) begin
               arready_n = 1'b0;
               ar_idx_n  = word_index(mem_axi_araddr);
               r_cnt_n   = CNT_W'(WAIT_CYCLES);
               r_state_n = R_WAIT;
            end
         end
         R_WAIT: begin
            if (r_cnt == '0) begin
               rd_sample_c = 1'b1;
               rvalid_n    = 1'b1;
               r_state_n   = R_DATA;
            end else begin
               r_cnt_n = r_cnt - CNT_W'(1);
            end
         end
         R_DATA: begin
            if (mem_axi_rready) begin
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
               r_state_n = R_IDLE;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
   end

   // State and output registers for both FSMs.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state   <= W_COLLECT;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         w_cnt     <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         r_state   <= R_IDLE;
         ar_idx_q  <= '0;
         r_cnt     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         w_state   <= w_state_n;
         aw_held   <= aw_held_n;
         w_held    <= w_held_n;
         aw_idx_q  <= aw_idx_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         w_cnt     <= w_cnt_n;
         awready_q <= awready_n;
         wready_q  <= wready_n;
         bvalid_q  <= bvalid_n;
         r_state   <= r_state_n;
         ar_idx_q  <= ar_idx_n;
         r_cnt     <= r_cnt_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         // Non-blocking read of mem gives read-before-write on a same-cycle commit.
         if (rd_sample_c) begin
            rdata_q <= mem[ar_idx_q];
         end
      end
   end

   // Memory commit; a reset in the commit cycle drops the write.
   always_ff @(posedge clk) begin
      if (mem_we_c && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
               mem[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign mem_axi_awready = awready_q;
   assign mem_axi_wready  = wready_q;
   assign mem_axi_bvalid  = bvalid_q;
   assign mem_axi_arready = arready_q;
   assign mem_axi_rvalid  = rvalid_q;
   assign mem_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Bench for axi4lite_sram_slave: one instance with no wait states and one
// with three, sharing a single stimulus bus selected by 'sel'.
module tb_axi4lite_sram_slave;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic [2:0]  prot;

   logic awready0, wready0, bvalid0, arready0, rvalid0;
   logic awready3, wready3, bvalid3, arready3, rvalid3;
   logic [31:0] rdata0, rdata3;

   logic awready, wready, bvalid, arready, rvalid;
   logic [31:0] rdata;

   assign awready = sel ? awready3 : awready0;
   assign wready  = sel ? wready3  : wready0;
   assign bvalid  = sel ? bvalid3  : bvalid0;
   assign arready = sel ? arready3 : arready0;
   assign rvalid  = sel ? rvalid3  : rvalid0;
   assign rdata   = sel ? rdata3   : rdata0;

   axi4lite_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .mem_axi_awvalid(awvalid & ~sel), .mem_axi_awready(awready0),
      .mem_axi_awaddr(awaddr), .mem_axi_awprot(prot),
      .mem_axi_wvalid(wvalid & ~sel), .mem_axi_wready(wready0),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid0), .mem_axi_bready(bready & ~sel),
      .mem_axi_arvalid(arvalid & ~sel), .mem_axi_arready(arready0),
      .mem_axi_araddr(araddr), .mem_axi_arprot(prot),
      .mem_axi_rvalid(rvalid0), .mem_axi_rready(rready & ~sel),
      .mem_axi_rdata(rdata0)
   );

   axi4lite_sram_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset),
      .mem_axi_awvalid(awvalid & sel), .mem_axi_awready(awready3),
      .mem_axi_awaddr(awaddr), .mem_axi_awprot(prot),
      .mem_axi_wvalid(wvalid & sel), .mem_axi_wready(wready3),
      .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid3), .mem_axi_bready(bready & sel),
      .mem_axi_arvalid(arvalid & sel), .mem_axi_arready(arready3),
      .mem_axi_araddr(araddr), .mem_axi_arprot(prot),
      .mem_axi_rvalid(rvalid3), .mem_axi_rready(rready & sel),
      .mem_axi_rdata(rdata3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles in which the selected bvalid is high.
   int bv_cnt = 0;
   always @(negedge clk) if (bvalid) bv_cnt <= bv_cnt + 1;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Write with AW/W presented at chosen cycle offsets; lat = cycles from
   // last handshake presentation to bvalid (-1 on timeout).
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_at, input int w_at, output int lat);
      bit aw_done = 0, w_done = 0, hs_aw, hs_w;
      int cyc = 0, n;
      bready = 1'b1;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = (cyc >= aw_at) && !aw_done;
         wvalid  = (cyc >= w_at)  && !w_done;
         hs_aw = awvalid && awready;
         hs_w  = wvalid  && wready;
         tick();
         cyc++;
         if (hs_aw) aw_done = 1;
         if (hs_w)  w_done  = 1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n = 1;
      while (!bvalid && n < 40) begin tick(); n++; end
      lat = (aw_done && w_done && bvalid) ? n : -1;
      tick();
   endtask

   // Read; lat = cycles from AR presentation with arready to rvalid.
   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output int lat);
      int n = 0;
      rready = 1'b1;
      arvalid = 1'b1; araddr = a;
      while (!arready && n < 40) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin tick(); lat++; end
      d = rdata;
      if (!rvalid) lat = -1;
      tick();
   endtask

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] raddr;
      logic [31:0] rexp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int lat, bs, bad;
      logic [31:0] d;

      vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF};
      vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0020, 32'h1122_3344};
      vecs[2] = '{32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0020, 32'h11BB_33DD};
      vecs[3] = '{32'h0000_1000, 32'h0000_0007, 4'hF, 32'h0000_0000, 32'h0000_0007};
      vecs[4] = '{32'h0000_0023, 32'h0000_0000, 4'h0, 32'h0000_0020, 32'h11BB_33DD};
      vecs[5] = '{32'h0000_0044, 32'h1234_5678, 4'hF, 32'h0000_0044, 32'h1234_5678};
      vecs[6] = '{32'h0000_0047, 32'hAB00_0000, 4'h8, 32'h0000_0044, 32'hAB34_5678};
      vecs[7] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0000_1FFC, 32'hCAFE_F00D};

      sel = 1'b0; prot = 3'b000;
      awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
      reset = 1'b1;
      repeat (3) tick();

      // Reset state
      chk("rst_ctl0", {27'd0, awready0, wready0, arready0, bvalid0, rvalid0}, 32'd0);
      chk("rst_ctl3", {27'd0, awready3, wready3, arready3, bvalid3, rvalid3}, 32'd0);
      chk("rst_rdata", rdata0 | rdata3, 32'd0);
      reset = 1'b0;
      tick();
      chk("rdy_after_rst0", {29'd0, awready0, wready0, arready0}, 32'd7);
      chk("rdy_after_rst3", {29'd0, awready3, wready3, arready3}, 32'd7);

      // Table: write, read back, check both latencies (no wait states)
      foreach (vecs[i]) begin
         axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 0, 0, lat);
         chk($sformatf("wr_lat[%0d]", i), 32'(lat), 32'd2);
         axi_read(vecs[i].raddr, d, lat);
         chk($sformatf("rd_lat[%0d]", i), 32'(lat), 32'd2);
         chk($sformatf("rd_data[%0d]", i), d, vecs[i].rexp);
      end

      // W first, AW three cycles later
      bs = bv_cnt; bad = 0; bready = 1'b1;
      wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF;
      tick();
      wvalid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         if (wready !== 1'b0) bad++;
         if (i == 3) begin awvalid = 1'b1; awaddr = 32'h40; end
         tick();
      end
      awvalid = 1'b0;
      repeat (8) tick();
      chk("w_first_wready_low", 32'(bad), 32'd0);
      chk("w_first_bvalid_count", 32'(bv_cnt - bs), 32'd1);
      axi_read(32'h40, d, lat);
      chk("w_first_rd", d, 32'h5);

      // AW first, W three cycles later
      bs = bv_cnt;
      axi_write(32'h48, 32'h5, 4'hF, 0, 3, lat);
      repeat (4) tick();
      chk("aw_first_bvalid_count", 32'(bv_cnt - bs), 32'd1);
      axi_read(32'h48, d, lat);
      chk("aw_first_rd", d, 32'h5);

      // Same-cycle commit and read sample of index 5
      axi_write(32'h14, 32'h1, 4'hF, 0, 0, lat);
      bready = 1'b1; rready = 1'b1;
      awvalid = 1'b1; awaddr = 32'h14; wvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h14;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      chk("collide_valids", {30'd0, bvalid, rvalid}, 32'd3);
      chk("collide_old_data", rdata, 32'h1);
      tick();
      axi_read(32'h14, d, lat);
      chk("collide_new_data", d, 32'h2);

      // Backpressure on the three-wait-state instance
      sel = 1'b1;
      tick();
      bready = 1'b0;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h80; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < 40) begin tick(); lat++; end
      chk("bp_wr_lat", 32'(lat), 32'd5);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad++;
         tick();
      end
      chk("bp_b_hold", 32'(bad), 32'd0);
      bready = 1'b1;
      tick();
      chk("bp_b_release", {30'd0, bvalid, awready}, 32'd1);

      rready = 1'b0;
      arvalid = 1'b1; araddr = 32'h80;
      tick();
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin tick(); lat++; end
      chk("bp_rd_lat", 32'(lat), 32'd5);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (rvalid !== 1'b1 || rdata !== 32'h0BAD_F00D || arready !== 1'b0) bad++;
         tick();
      end
      chk("bp_r_hold", 32'(bad), 32'd0);
      chk("bp_r_arready_before", {31'd0, arready}, 32'd0);
      rready = 1'b1;
      tick();
      chk("bp_r_release", {30'd0, rvalid, arready}, 32'd1);
      sel = 1'b0;
      tick();

      // Reset while AW is held and W has not arrived
      axi_write(32'h30, 32'h600D_CAFE, 4'hF, 0, 0, lat);
      axi_read(32'h30, d, lat);
      chk("pre_rst_rd", d, 32'h600D_CAFE);
      awvalid = 1'b1; awaddr = 32'h30;
      tick();
      awvalid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_ctl", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      tick();
      chk("mid_rst_rdy", {29'd0, awready, wready, arready}, 32'd7);
      bs = bv_cnt;
      wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      tick();
      wvalid = 1'b0;
      repeat (10) tick();
      chk("mid_rst_no_bvalid", 32'(bv_cnt - bs), 32'd0);
      axi_read(32'h30, d, lat);
      chk("mid_rst_mem_kept", d, 32'h600D_CAFE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
